// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store bridge: RV32I funct3 width codes and FSM states.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

endpackage

// File: rtl/lsu_data_align.sv
// Byte/half lane handling: load extraction with sign/zero extension, and store merge for RMW.
module lsu_data_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr,
   input  logic [31:0] rdata_word,
   input  logic [31:0] wdata,
   output logic [31:0] load_result,
   output logic [31:0] merged_word
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (addr)
         2'd0:    byte_sel = rdata_word[7:0];
         2'd1:    byte_sel = rdata_word[15:8];
         2'd2:    byte_sel = rdata_word[23:16];
         default: byte_sel = rdata_word[31:24];
      endcase
      half_sel = addr[1] ? rdata_word[31:16] : rdata_word[15:0];

      case (funct3)
         F3_B:    load_result = {{24{byte_sel[7]}}, byte_sel};
         F3_H:    load_result = {{16{half_sel[15]}}, half_sel};
         F3_BU:   load_result = {24'd0, byte_sel};
         F3_HU:   load_result = {16'd0, half_sel};
         default: load_result = rdata_word;
      endcase

      merged_word = rdata_word;
      case (funct3)
         F3_B: begin
            case (addr)
               2'd0:    merged_word[7:0]   = wdata[7:0];
               2'd1:    merged_word[15:8]  = wdata[7:0];
               2'd2:    merged_word[23:16] = wdata[7:0];
               default: merged_word[31:24] = wdata[7:0];
            endcase
         end
         F3_H: begin
            if (addr[1]) merged_word[31:16] = wdata[15:0];
            else         merged_word[15:0]  = wdata[15:0];
         end
         default: merged_word = wdata;
      endcase
   end

endmodule

// File: rtl/lsu_mem_bridge.sv
// Load/store bridge from the core memory stage to a word-only data memory.
// Sub-word stores are done as read-modify-write; faulting accesses never touch memory.
module lsu_mem_bridge
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_BYTES = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   input  logic [31:0] mem_rdata
);

   state_t      state;
   logic        we_q;
   logic [2:0]  funct3_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] mem_wdata_q;
   logic        req_err;
   logic        illegal;
   logic        misaligned;
   logic [31:0] load_result;
   logic [31:0] merged_word;

   always_comb begin
      illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111) ||
                (req_we && ((req_funct3 == F3_BU) || (req_funct3 == F3_HU)));
      misaligned = (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && req_addr[0]) ||
                   ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
      req_err = illegal || misaligned || (req_addr >= MEM_BYTES);
   end

   lsu_data_align u_align (
      .funct3      (funct3_q),
      .addr        (addr_q[1:0]),
      .rdata_word  (mem_rdata),
      .wdata       (wdata_q),
      .load_result (load_result),
      .merged_word (merged_word)
   );

   // The merged word is captured straight from mem_rdata at the READ edge,
   // so WRITE drives a registered value and no separate read-data register is needed.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         req_ready   <= 1'b1;
         resp_valid  <= 1'b0;
         resp_rdata  <= '0;
         resp_err    <= 1'b0;
         we_q        <= 1'b0;
         funct3_q    <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         mem_wdata_q <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  we_q      <= req_we;
                  funct3_q  <= req_funct3;
                  addr_q    <= req_addr;
                  wdata_q   <= req_wdata;
                  req_ready <= 1'b0;
                  if (req_err) begin
                     state      <= ST_RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                  end else if (!req_we) begin
                     state <= ST_READ;
                  end else if (req_funct3 == F3_W) begin
                     state       <= ST_WRITE;
                     mem_wdata_q <= req_wdata;
                  end else begin
                     state <= ST_READ;
                  end
               end
            end
            ST_READ: begin
               if (we_q) begin
                  state       <= ST_WRITE;
                  mem_wdata_q <= merged_word;
               end else begin
                  state      <= ST_RESP;
                  resp_valid <= 1'b1;
                  resp_rdata <= load_result;
               end
            end
            ST_WRITE: begin
               state       <= ST_RESP;
               mem_wdata_q <= '0;
               resp_valid  <= 1'b1;
            end
            ST_RESP: begin
               state      <= ST_IDLE;
               req_ready  <= 1'b1;
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               resp_rdata <= '0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign mem_addr  = {addr_q[31:2], 2'b00};
   assign mem_wdata = mem_wdata_q;
   assign mem_we    = (state == ST_WRITE) && !rst;

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Directed bench for lsu_mem_bridge with a word-addressed memory model.
module tb_lsu_mem_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic [31:0] mem_rdata;

   logic [31:0] mem [0:4095];
   int          we_cnt = 0;
   logic [31:0] last_w = '0;
   int          n_checks = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   lsu_mem_bridge #(.MEM_BYTES(4096)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we),
      .mem_rdata  (mem_rdata)
   );

   assign mem_rdata = mem[mem_addr[13:2]];

   always @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr[13:2]] <= mem_wdata;
         last_w <= mem_wdata;
         we_cnt <= we_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Presents one request, returns response data/error and cycles from accept edge to resp_valid.
   task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rd, output logic err,
                       output int lat);
      @(negedge clk);
      check("ready_idle", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0;
      rd = '0;
      err = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         lat++;
         if (resp_valid) break;
      end
      if (!resp_valid) begin
         check("resp_timeout", 32'd0, 32'd1);
      end else begin
         rd = resp_rdata;
         err = resp_err;
         check("ready_in_resp", {31'd0, req_ready}, 32'd0);
      end
   endtask

   logic [31:0] rd;
   logic        err;
   int          lat;
   int          w0;

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = '0;
      mem[4] = 32'h8899AABB;
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
      repeat (3) @(negedge clk);
      check("rst_ready", {31'd0, req_ready}, 32'd1);
      check("rst_rvalid", {31'd0, resp_valid}, 32'd0);
      check("rst_rdata", resp_rdata, 32'd0);
      check("rst_err", {31'd0, resp_err}, 32'd0);
      check("rst_mem_we", {31'd0, mem_we}, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      rst = 1'b0;

      xact(1'b0, 3'b000, 32'h13, 32'h0, rd, err, lat);
      check("lb_data", rd, 32'hFFFFFF88);
      check("lb_lat", lat, 2);
      check("lb_err", {31'd0, err}, 32'd0);
      check("lb_no_we", we_cnt, 0);

      xact(1'b0, 3'b101, 32'h10, 32'h0, rd, err, lat);
      check("lhu_data", rd, 32'h0000AABB);
      xact(1'b0, 3'b001, 32'h12, 32'h0, rd, err, lat);
      check("lh_data", rd, 32'hFFFF8899);
      xact(1'b0, 3'b010, 32'h10, 32'h0, rd, err, lat);
      check("lw_data", rd, 32'h8899AABB);
      check("lw_lat", lat, 2);
      xact(1'b0, 3'b100, 32'h13, 32'h0, rd, err, lat);
      check("lbu_data", rd, 32'h00000088);
      xact(1'b0, 3'b000, 32'h10, 32'h0, rd, err, lat);
      check("lb_lane0", rd, 32'hFFFFFFBB);

      xact(1'b1, 3'b000, 32'h11, 32'h123456CC, rd, err, lat);
      check("sb_lat", lat, 3);
      check("sb_we_cnt", we_cnt, 1);
      check("sb_word", last_w, 32'h8899CCBB);
      check("sb_rdata", rd, 32'd0);
      check("sb_err", {31'd0, err}, 32'd0);
      xact(1'b0, 3'b010, 32'h10, 32'h0, rd, err, lat);
      check("lw_after_sb", rd, 32'h8899CCBB);

      xact(1'b1, 3'b001, 32'h11, 32'h0000FFFF, rd, err, lat);
      check("sh_mis_err", {31'd0, err}, 32'd1);
      check("sh_mis_lat", lat, 1);
      check("sh_mis_no_we", we_cnt, 1);
      xact(1'b0, 3'b010, 32'h1000, 32'h0, rd, err, lat);
      check("lw_oor_err", {31'd0, err}, 32'd1);
      check("lw_oor_rdata", rd, 32'd0);
      check("lw_oor_lat", lat, 1);
      xact(1'b0, 3'b010, 32'h12, 32'h0, rd, err, lat);
      check("lw_mis_err", {31'd0, err}, 32'd1);
      xact(1'b0, 3'b011, 32'h10, 32'h0, rd, err, lat);
      check("f3_011_err", {31'd0, err}, 32'd1);
      xact(1'b1, 3'b100, 32'h10, 32'h55, rd, err, lat);
      check("store_bu_err", {31'd0, err}, 32'd1);
      check("store_bu_no_we", we_cnt, 1);
      xact(1'b0, 3'b010, 32'hFFC, 32'h0, rd, err, lat);
      check("lw_top_err", {31'd0, err}, 32'd0);

      xact(1'b1, 3'b010, 32'h20, 32'hDEADBEEF, rd, err, lat);
      check("sw_lat", lat, 2);
      check("sw_word", last_w, 32'hDEADBEEF);
      xact(1'b0, 3'b010, 32'h20, 32'h0, rd, err, lat);
      check("b2b_lw", rd, 32'hDEADBEEF);

      xact(1'b1, 3'b001, 32'h12, 32'h00007777, rd, err, lat);
      check("sh_lat", lat, 3);
      check("sh_word", last_w, 32'h7777CCBB);
      xact(1'b0, 3'b000, 32'h12, 32'h0, rd, err, lat);
      check("lb_after_sh", rd, 32'h00000077);

      // Reset asserted during the WRITE cycle of an SB must suppress the write.
      w0 = we_cnt;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h10; req_wdata = 32'h000000AA;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rstw_in_write", {31'd0, mem_we}, 32'd1);
      check("rstw_merged", mem_wdata, 32'h7777CCAA);
      rst = 1'b1;
      #1 check("rstw_we_gated", {31'd0, mem_we}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      check("rstw_no_pulse", we_cnt, w0);
      check("rstw_word4", mem[4], 32'h7777CCBB);
      @(negedge clk);
      check("rstw_ready", {31'd0, req_ready}, 32'd1);
      check("rstw_rvalid", {31'd0, resp_valid}, 32'd0);
      check("rstw_rdata", resp_rdata, 32'd0);
      check("rstw_err", {31'd0, resp_err}, 32'd0);
      check("rstw_mem_we", {31'd0, mem_we}, 32'd0);
      check("rstw_mem_wdata", mem_wdata, 32'd0);
      check("rstw_mem_addr", mem_addr, 32'd0);

      xact(1'b0, 3'b010, 32'h10, 32'h0, rd, err, lat);
      check("lw_post_rst", rd, 32'h7777CCBB);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
